// File: rtl/combination_lock_param_if.sv
// Key/switch inputs and status outputs of the combination lock.
// The master drives the keypad side, the slave is the lock itself.
interface combination_lock_param_if #(
  parameter int DIGITS = 3,
  parameter int WIDTH  = 4
);
  localparam int PW = $clog2(DIGITS + 1);

  logic          Enter;
  logic [WIDTH-1:0] Digit;
  logic          Program;
  logic          Relock;
  logic          Locked;
  logic          Unlocked;
  logic          LockedOut;
  logic          Fail;
  logic [PW-1:0] Progress;

  modport master (
    output Enter, Digit, Program, Relock,
    input  Locked, Unlocked, LockedOut,
    input  Fail, Progress
  );

  modport slave (
    input  Enter, Digit, Program, Relock,
    output Locked, Unlocked, LockedOut,
    output Fail, Progress
  );
endinterface

// File: rtl/combination_lock_param.sv
// N-digit combination lock with run-time reprogramming,
// failed-attempt lockout and inter-digit inactivity timeout.
module combination_lock_param #(
  parameter int DIGITS = 3,
  parameter int WIDTH = 4,
  parameter logic [DIGITS*WIDTH-1:0] DEFAULT_CODE = 12'h97D,
  parameter int MAX_FAILS = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 32
) (
  input logic Clk,
  input logic Reset,
  combination_lock_param_if.slave bus
);
  localparam int PW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] LAST = PW'(DIGITS - 1);
  localparam logic [FW-1:0] FMAX = FW'(MAX_FAILS);
  localparam logic [LW-1:0] LLOAD = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ENTRY, OPEN, PROGRAM, LOCKOUT
  } state_t;

  state_t state;
  logic [DIGITS*WIDTH-1:0] code;
  logic [DIGITS*WIDTH-1:0] shadow;
  logic [DIGITS*WIDTH-1:0] shadow_nx;
  logic enter_q;
  logic mismatch;
  logic [FW-1:0] fail_cnt;
  logic [LW-1:0] lock_tmr;
  logic [TW-1:0] idle;
  logic [PW-1:0] progress;
  logic locked;
  logic unlocked;
  logic locked_out;
  logic fail;

  logic press;
  logic last;
  logic miss;
  logic expire;
  logic [WIDTH-1:0] cur;

  assign press = bus.Enter & ~enter_q;
  assign last = (progress == LAST);
  assign cur = code[progress*WIDTH +: WIDTH];
  assign miss = mismatch | (bus.Digit != cur);
  assign expire = ~press & (progress != '0) & (idle == TLAST);

  always_comb begin
    shadow_nx = shadow;
    shadow_nx[progress*WIDTH +: WIDTH] = bus.Digit;
  end

  function automatic logic [2:0] flags(state_t s);
    unique case (s)
      ENTRY:   flags = 3'b100;
      OPEN:    flags = 3'b010;
      PROGRAM: flags = 3'b010;
      LOCKOUT: flags = 3'b101;
      default: flags = 3'b100;
    endcase
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ENTRY;
      code <= DEFAULT_CODE;
      shadow <= DEFAULT_CODE;
      // Treat the key as already down so a held key is not a press.
      enter_q <= 1'b1;
      mismatch <= 1'b0;
      fail_cnt <= '0;
      lock_tmr <= '0;
      idle <= '0;
      progress <= '0;
      {locked, unlocked, locked_out} <= flags(ENTRY);
      fail <= 1'b0;
    end else begin
      enter_q <= bus.Enter;
      fail <= 1'b0;
      unique case (state)
        ENTRY: begin
          if (press) begin
            idle <= '0;
            if (last) begin
              progress <= '0;
              mismatch <= 1'b0;
              if (!miss) begin
                state <= OPEN;
                fail_cnt <= '0;
                {locked, unlocked, locked_out} <= flags(OPEN);
              end else begin
                fail <= 1'b1;
                if (fail_cnt == FMAX - 1'b1) begin
                  fail_cnt <= FMAX;
                  lock_tmr <= LLOAD;
                  state <= LOCKOUT;
                  {locked, unlocked, locked_out} <= flags(LOCKOUT);
                end else begin
                  fail_cnt <= fail_cnt + 1'b1;
                end
              end
            end else begin
              progress <= progress + 1'b1;
              mismatch <= miss;
            end
          end else if (expire) begin
            progress <= '0;
            mismatch <= 1'b0;
            idle <= '0;
          end else if (progress != '0) begin
            idle <= idle + 1'b1;
          end
        end
        LOCKOUT: begin
          if (lock_tmr == '0) begin
            state <= ENTRY;
            fail_cnt <= '0;
            progress <= '0;
            {locked, unlocked, locked_out} <= flags(ENTRY);
          end else begin
            lock_tmr <= lock_tmr - 1'b1;
          end
        end
        OPEN: begin
          if (bus.Relock) begin
            state <= ENTRY;
            progress <= '0;
            idle <= '0;
            {locked, unlocked, locked_out} <= flags(ENTRY);
          end else if (press && bus.Program) begin
            state <= PROGRAM;
            progress <= '0;
            idle <= '0;
          end
        end
        PROGRAM: begin
          if (bus.Relock) begin
            state <= ENTRY;
            progress <= '0;
            idle <= '0;
            {locked, unlocked, locked_out} <= flags(ENTRY);
          end else if (press) begin
            shadow <= shadow_nx;
            idle <= '0;
            if (last) begin
              code <= shadow_nx;
              state <= OPEN;
              progress <= '0;
            end else begin
              progress <= progress + 1'b1;
            end
          end else if (expire) begin
            state <= OPEN;
            progress <= '0;
            idle <= '0;
          end else if (progress != '0) begin
            idle <= idle + 1'b1;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

  assign bus.Locked = locked;
  assign bus.Unlocked = unlocked;
  assign bus.LockedOut = locked_out;
  assign bus.Fail = fail;
  assign bus.Progress = progress;
endmodule

// File: tb/tb_combination_lock_param.sv
// Scoreboard bench for combination_lock_param: stimulus queues
// expected status, a negedge monitor pops and compares.
module tb_combination_lock_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  combination_lock_param_if #(.DIGITS(3), .WIDTH(4)) bus ();

  combination_lock_param dut (
    .Clk(clk),
    .Reset(rst),
    .bus(bus)
  );

  typedef struct {
    string name;
    logic [5:0] v;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails = 0;
  logic probe = 1'b0;
  logic probe_q = 1'b0;

  localparam logic [2:0] L = 3'b100;
  localparam logic [2:0] O = 3'b010;
  localparam logic [2:0] X = 3'b101;

  function automatic logic [5:0] st(logic [2:0] f, logic fl,
                                    logic [1:0] p);
    return {f, fl, p};
  endfunction

  always @(posedge clk) probe_q <= probe;

  always @(negedge clk) begin
    if (probe_q) begin
      logic [5:0] act;
      exp_t e;
      act = {bus.Locked, bus.Unlocked, bus.LockedOut,
             bus.Fail, bus.Progress};
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected sample: got %b, none queued", act);
      end else begin
        e = q.pop_front();
        if (act !== e.v) begin
          fails++;
          $display("FAIL %s: got %b want %b (L U LO F P[1:0])",
                   e.name, act, e.v);
        end
      end
    end
  end

  task automatic press(input logic [3:0] d, input logic p,
                       input logic [5:0] e, input string n);
    exp_t x;
    @(negedge clk);
    bus.Digit = d;
    bus.Program = p;
    bus.Enter = 1'b1;
    probe = 1'b1;
    x.name = n;
    x.v = e;
    q.push_back(x);
    @(negedge clk);
    bus.Enter = 1'b0;
    bus.Program = 1'b0;
    probe = 1'b0;
  endtask

  task automatic check(input logic [5:0] e, input string n);
    exp_t x;
    @(negedge clk);
    probe = 1'b1;
    x.name = n;
    x.v = e;
    q.push_back(x);
    @(negedge clk);
    probe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic relock(input string n);
    bus.Relock = 1'b1;
    check(st(L, 0, 0), n);
    bus.Relock = 1'b0;
  endtask

  task automatic wrong(input logic [2:0] f, input string n);
    press(4'hD, 0, st(L, 0, 1), {n, "_d0"});
    press(4'h0, 0, st(L, 0, 2), {n, "_d1"});
    press(4'h9, 0, st(f, 1, 0), {n, "_d2"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Enter = 1'b0;
    bus.Digit = '0;
    bus.Program = 1'b0;
    bus.Relock = 1'b0;
    idle(3);
    check(st(L, 0, 0), "reset_state");
    rst = 1'b0;

    press(4'hD, 0, st(L, 0, 1), "ok_d0");
    press(4'h7, 0, st(L, 0, 2), "ok_d1");
    press(4'h9, 0, st(O, 0, 0), "ok_open");
    check(st(O, 0, 0), "ok_stay_open");
    relock("ok_relock");

    wrong(L, "bad1");
    check(st(L, 0, 0), "bad1_fail_one_cycle");
    wrong(L, "bad2");
    wrong(X, "bad3");
    press(4'hD, 0, st(X, 0, 0), "lo_ign_d0");
    press(4'h7, 0, st(X, 0, 0), "lo_ign_d1");
    press(4'h9, 0, st(X, 0, 0), "lo_ign_d2");
    check(st(X, 0, 0), "lo_hold");
    idle(5);
    check(st(X, 0, 0), "lo_last_cycle");
    check(st(L, 0, 0), "lo_exit");
    press(4'hD, 0, st(L, 0, 1), "post_lo_d0");
    press(4'h7, 0, st(L, 0, 2), "post_lo_d1");
    press(4'h9, 0, st(O, 0, 0), "post_lo_open");
    relock("post_lo_relock");

    press(4'hD, 0, st(L, 0, 1), "to_d0");
    press(4'h7, 0, st(L, 0, 2), "to_d1");
    idle(29);
    check(st(L, 0, 2), "to_before");
    check(st(L, 0, 0), "to_after");
    press(4'hD, 0, st(L, 0, 1), "to2_d0");
    press(4'h7, 0, st(L, 0, 2), "to2_d1");
    press(4'h9, 0, st(O, 0, 0), "to2_open");

    press(4'h5, 1, st(O, 0, 0), "pg_start");
    press(4'h1, 0, st(O, 0, 1), "pg_d0");
    press(4'h2, 0, st(O, 0, 2), "pg_d1");
    press(4'h3, 0, st(O, 0, 0), "pg_done");
    relock("pg_relock");
    press(4'hD, 0, st(L, 0, 1), "old_d0");
    press(4'h7, 0, st(L, 0, 2), "old_d1");
    press(4'h9, 0, st(L, 1, 0), "old_code_fail");
    press(4'h1, 0, st(L, 0, 1), "new_d0");
    press(4'h2, 0, st(L, 0, 2), "new_d1");
    press(4'h3, 0, st(O, 0, 0), "new_open");

    press(4'h0, 1, st(O, 0, 0), "ab_start");
    press(4'h4, 0, st(O, 0, 1), "ab_d0");
    press(4'h5, 0, st(O, 0, 2), "ab_d1");
    relock("ab_relock");
    press(4'h1, 0, st(L, 0, 1), "ab_keep_d0");
    press(4'h2, 0, st(L, 0, 2), "ab_keep_d1");
    press(4'h3, 0, st(O, 0, 0), "ab_keep_open");

    press(4'h0, 1, st(O, 0, 0), "pto_start");
    press(4'h6, 0, st(O, 0, 1), "pto_d0");
    idle(40);
    check(st(O, 0, 0), "pto_abort_open");
    relock("pto_relock");
    press(4'h1, 0, st(L, 0, 1), "pto_keep_d0");
    press(4'h2, 0, st(L, 0, 2), "pto_keep_d1");
    press(4'h3, 0, st(O, 0, 0), "pto_keep_open");
    relock("pto_relock2");

    press(4'h1, 0, st(L, 0, 1), "rm_d0");
    press(4'h2, 0, st(L, 0, 2), "rm_d1");
    @(negedge clk);
    rst = 1'b1;
    bus.Enter = 1'b1;
    idle(2);
    rst = 1'b0;
    check(st(L, 0, 0), "rm_no_press");
    check(st(L, 0, 0), "rm_no_press2");
    bus.Enter = 1'b0;
    press(4'hD, 0, st(L, 0, 1), "rm_def_d0");
    press(4'h7, 0, st(L, 0, 2), "rm_def_d1");
    press(4'h9, 0, st(O, 0, 0), "rm_def_open");
    relock("rm_relock");

    wrong(L, "rl1");
    wrong(L, "rl2");
    wrong(X, "rl3");
    @(negedge clk);
    rst = 1'b1;
    bus.Enter = 1'b1;
    idle(2);
    rst = 1'b0;
    check(st(L, 0, 0), "rl_reset_entry");
    bus.Enter = 1'b0;
    wrong(L, "rl_cnt1");
    wrong(L, "rl_cnt2");

    idle(3);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d left want 0",
               q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
